// File: rtl/arith_bit_packer.sv
// Packs variable-length MSB-first bit chunks (0..16 bits, left-aligned) into OUT_W-bit words.
// Latency: a word completed at edge N is at the FIFO head after edge N (1 cycle when empty).
// Backpressure: none upstream; out_valid/out_ready downstream, a full FIFO drops words (sticky overflow).
//
// Ports: clk, rst_n (async active-low); bits_in/bits_count_in/bits_valid_in chunk input;
// flush_in ends a stream; out_data/out_bits/out_last/out_valid/out_ready word handshake;
// fifo_level, overflow status. Optional macro ARITH_BIT_PACKER_STATS_EN adds
// total_bits and dropped_words saturating counters.

module arith_bit_packer_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_vld,
    input  logic [W-1:0]               push_dat,
    input  logic                       pop,
    output logic                       push_ok,
    output logic [W-1:0]               head_dat,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         full;

    // Extra pointer bit distinguishes full from empty; wraps naturally for power-of-two depth.
    assign level    = wr_ptr - rd_ptr;
    assign empty    = (level == '0);
    assign full     = (level == (AW+1)'(DEPTH));
    // A same-cycle pop frees the slot the new word lands in.
    assign push_ok  = push_vld && (!full || pop);
    assign head_dat = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr[AW-1:0]] <= push_dat;
    end
endmodule

module arith_bit_packer #(
    parameter int OUT_W      = 32,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [15:0]                   bits_in,
    input  logic [4:0]                    bits_count_in,
    input  logic                          bits_valid_in,
    input  logic                          flush_in,
    output logic [OUT_W-1:0]              out_data,
    output logic [$clog2(OUT_W):0]        out_bits,
    output logic                          out_last,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
`ifdef ARITH_BIT_PACKER_STATS_EN
    output logic [31:0]                   total_bits,
    output logic [15:0]                   dropped_words,
`endif
    output logic                          overflow
);
    localparam int ACC_W = OUT_W + 16;
    localparam int CW    = $clog2(ACC_W + 1);
    localparam int BW    = $clog2(OUT_W) + 1;
    localparam int EW    = OUT_W + BW + 1;

    typedef enum logic {RUN, FLUSH} state_t;

    state_t           state, state_nxt;
    logic [ACC_W-1:0] acc, acc_nxt, base_acc, app_acc;
    logic [CW-1:0]    acc_cnt, cnt_nxt, base_cnt, app_cnt;
    logic [4:0]       chunk_cnt;
    logic [15:0]      chunk;
    logic             push_vld;
    logic [OUT_W-1:0] push_word;
    logic [BW-1:0]    push_bits;
    logic             push_last;
    logic             push_ok;
    logic             pop;
    logic             fifo_empty;
    logic [EW-1:0]    head_dat;

    always_comb begin
        state_nxt = state;
        push_vld  = 1'b0;
        push_word = '0;
        push_bits = '0;
        push_last = 1'b0;
        base_acc  = acc;
        base_cnt  = acc_cnt;

        chunk_cnt = 5'd0;
        if (bits_valid_in)
            chunk_cnt = (bits_count_in > 5'd16) ? 5'd16 : bits_count_in;
        // Keep only the top chunk_cnt bits so stray low bits never leak into the stream.
        chunk = (chunk_cnt == 5'd0) ? 16'h0000 : (bits_in & (16'hFFFF << (5'd16 - chunk_cnt)));

        // FLUSH emits the previous stream's tail first; a chunk this cycle starts a fresh accumulator.
        if (state == FLUSH) begin
            push_vld  = 1'b1;
            push_word = acc[ACC_W-1 -: OUT_W];
            push_bits = BW'(acc_cnt);
            push_last = 1'b1;
            base_acc  = '0;
            base_cnt  = '0;
            state_nxt = RUN;
        end

        app_acc = base_acc | ({chunk, {OUT_W{1'b0}}} >> base_cnt);
        app_cnt = base_cnt + CW'(chunk_cnt);
        acc_nxt = app_acc;
        cnt_nxt = app_cnt;

        // With OUT_W=16 a full chunk in FLUSH can leave acc_cnt == OUT_W; the word then goes out
        // on the following RUN cycle, and the accumulator is wide enough to hold it meanwhile.
        if (state == RUN) begin
            if (app_cnt >= CW'(OUT_W)) begin
                push_vld  = 1'b1;
                push_word = app_acc[ACC_W-1 -: OUT_W];
                push_bits = BW'(OUT_W);
                acc_nxt   = app_acc << OUT_W;
                cnt_nxt   = app_cnt - CW'(OUT_W);
            end
            if (flush_in)
                state_nxt = FLUSH;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= RUN;
            acc     <= '0;
            acc_cnt <= '0;
        end else begin
            state   <= state_nxt;
            acc     <= acc_nxt;
            acc_cnt <= cnt_nxt;
        end
    end

    assign pop = out_valid && out_ready;

    arith_bit_packer_fifo #(
        .W     (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_vld (push_vld),
        .push_dat ({push_last, push_bits, push_word}),
        .pop      (pop),
        .push_ok  (push_ok),
        .head_dat (head_dat),
        .empty    (fifo_empty),
        .level    (fifo_level)
    );

    // Head fields are gated so the outputs read zero while the FIFO is empty (memory is not reset).
    assign out_valid = !fifo_empty;
    assign out_data  = out_valid ? head_dat[OUT_W-1:0]        : '0;
    assign out_bits  = out_valid ? head_dat[OUT_W +: BW]      : '0;
    assign out_last  = out_valid ? head_dat[EW-1]             : 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            overflow <= 1'b0;
        else if (push_vld && !push_ok)
            overflow <= 1'b1;
    end

`ifdef ARITH_BIT_PACKER_STATS_EN
    logic [32:0] bits_sum;
    assign bits_sum = {1'b0, total_bits} + 33'(push_bits);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            total_bits    <= '0;
            dropped_words <= '0;
        end else begin
            if (push_ok)
                total_bits <= bits_sum[32] ? 32'hFFFF_FFFF : bits_sum[31:0];
            if (push_vld && !push_ok && dropped_words != 16'hFFFF)
                dropped_words <= dropped_words + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_arith_bit_packer.sv
module tb_arith_bit_packer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] bits_in = '0;
    logic [4:0]  bits_count_in = '0;
    logic        bits_valid_in = 1'b0;
    logic        flush_in = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic [5:0]  out_bits;
    logic        out_last;
    logic        out_valid;
    logic [3:0]  fifo_level;
    logic        overflow;
`ifdef ARITH_BIT_PACKER_STATS_EN
    logic [31:0] total_bits;
    logic [15:0] dropped_words;
`endif

    typedef struct packed {
        logic [31:0] d;
        logic [5:0]  b;
        logic        l;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    arith_bit_packer #(.OUT_W(32), .FIFO_DEPTH(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bits_in       (bits_in),
        .bits_count_in (bits_count_in),
        .bits_valid_in (bits_valid_in),
        .flush_in      (flush_in),
        .out_data      (out_data),
        .out_bits      (out_bits),
        .out_last      (out_last),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .fifo_level    (fifo_level),
`ifdef ARITH_BIT_PACKER_STATS_EN
        .total_bits    (total_bits),
        .dropped_words (dropped_words),
`endif
        .overflow      (overflow)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: compare each accepted head word against the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $error("FAIL unexpected_word: observed %0h, expected no word", out_data);
            end else begin
                e = sb.pop_front();
                check("word_data", {32'h0, out_data}, {32'h0, e.d});
                check("word_bits", {58'h0, out_bits}, {58'h0, e.b});
                check("word_last", {63'h0, out_last}, {63'h0, e.l});
            end
        end
    end

    task automatic expect_word(input logic [31:0] d, input logic [5:0] b, input logic l);
        exp_t e;
        e.d = d;
        e.b = b;
        e.l = l;
        sb.push_back(e);
    endtask

    // Present one cycle of input, consumed at the next rising edge; returns 1 time unit after it.
    task automatic drive(input logic [15:0] b, input logic [4:0] c, input logic v, input logic f);
        bits_in       = b;
        bits_count_in = c;
        bits_valid_in = v;
        flush_in      = f;
        @(posedge clk);
        #1;
        bits_in       = '0;
        bits_count_in = '0;
        bits_valid_in = 1'b0;
        flush_in      = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic full_word(input logic [31:0] w, input logic expected);
        if (expected)
            expect_word(w, 6'd32, 1'b0);
        drive(w[31:16], 5'd16, 1'b1, 1'b0);
        drive(w[15:0],  5'd16, 1'b1, 1'b0);
    endtask

    initial begin
        #100000;
        $error("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] w;
        int          t;

        // Outputs during reset
        #12;
        check("rst_out_valid",  {63'h0, out_valid},  64'h0);
        check("rst_out_data",   {32'h0, out_data},   64'h0);
        check("rst_out_bits",   {58'h0, out_bits},   64'h0);
        check("rst_out_last",   {63'h0, out_last},   64'h0);
        check("rst_fifo_level", {60'h0, fifo_level}, 64'h0);
        check("rst_overflow",   {63'h0, overflow},   64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;

        // Two full chunks make one word, visible one cycle after the completing chunk
        expect_word(32'hABCD_1234, 6'd32, 1'b0);
        drive(16'hABCD, 5'd16, 1'b1, 1'b0);
        check("t1_no_early_valid", {63'h0, out_valid}, 64'h0);
        drive(16'h1234, 5'd16, 1'b1, 1'b0);
        check("t1_valid_latency", {63'h0, out_valid}, 64'h1);
        check("t1_data", {32'h0, out_data}, 64'hABCD_1234);

        // Masking of bits below the count, then a zero-count chunk leaves acc_cnt alone
        expect_word(32'hFFFF_FFFF, 6'd32, 1'b0);
        repeat (8) drive(16'hFFFF, 5'd4, 1'b1, 1'b0);
        drive(16'hFFFF, 5'd0, 1'b1, 1'b0);
        idle(2);
        check("zero_cnt_level", {60'h0, fifo_level}, 64'h0);
        check("zero_cnt_no_word", {63'h0, out_valid}, 64'h0);
        full_word(32'h1234_ABCD, 1'b1);

        // Count above 16 clamps to 16
        expect_word(32'h5555_AAAA, 6'd32, 1'b0);
        drive(16'h5555, 5'd20, 1'b1, 1'b0);
        drive(16'hAAAA, 5'd16, 1'b1, 1'b0);

        // Partial flush: 101 + 11111
        expect_word(32'hBF00_0000, 6'd8, 1'b1);
        drive(16'hA000, 5'd3, 1'b1, 1'b0);
        drive(16'hF800, 5'd5, 1'b1, 1'b0);
        drive(16'h0000, 5'd0, 1'b0, 1'b1);
        idle(3);
        check("pflush_level", {60'h0, fifo_level}, 64'h0);

        // Empty flush
        expect_word(32'h0, 6'd0, 1'b1);
        drive(16'h0000, 5'd0, 1'b0, 1'b1);
        idle(3);

        // Flush with a same-cycle chunk
        expect_word(32'h8000_0000, 6'd1, 1'b1);
        drive(16'h8000, 5'd1, 1'b1, 1'b1);
        idle(3);

        // A chunk during FLUSH starts the next stream; flush_in during FLUSH is ignored
        expect_word(32'hC000_0000, 6'd2, 1'b1);
        expect_word(32'hABCD_1234, 6'd32, 1'b0);
        drive(16'hC000, 5'd2, 1'b1, 1'b1);
        drive(16'hABCD, 5'd16, 1'b1, 1'b1);
        drive(16'h1234, 5'd16, 1'b1, 1'b0);
        idle(3);
        check("next_stream_level", {60'h0, fifo_level}, 64'h0);

        // Push into a full FIFO with a simultaneous pop is accepted
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            w = {16'(16'h1000 + i), 16'(16'h2000 + i)};
            full_word(w, 1'b1);
        end
        check("full_level", {60'h0, fifo_level}, 64'h8);
        expect_word(32'h3333_4444, 6'd32, 1'b0);
        drive(16'h3333, 5'd16, 1'b1, 1'b0);
        out_ready = 1'b1;
        drive(16'h4444, 5'd16, 1'b1, 1'b0);
        check("push_pop_full_no_ovf", {63'h0, overflow}, 64'h0);
        idle(12);
        check("push_pop_drained", {60'h0, fifo_level}, 64'h0);

        // Overflow: nine words into eight slots; the ninth is dropped
        out_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            w = {16'(16'h5000 + i), 16'(16'h6000 + i)};
            full_word(w, (i < 8));
        end
        idle(1);
        check("ovf_level", {60'h0, fifo_level}, 64'h8);
        check("ovf_flag", {63'h0, overflow}, 64'h1);
        check("ovf_head_stable", {32'h0, out_data}, 64'h5000_6000);
`ifdef ARITH_BIT_PACKER_STATS_EN
        check("ovf_dropped_words", {48'h0, dropped_words}, 64'h1);
`endif
        out_ready = 1'b1;
        idle(10);
        check("ovf_drained", {60'h0, fifo_level}, 64'h0);
        check("ovf_sticky", {63'h0, overflow}, 64'h1);

        // Reset mid-stream: 3 words queued plus 20 accumulated bits
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            w = {16'(16'h7000 + i), 16'(16'h8000 + i)};
            full_word(w, 1'b0);
        end
        drive(16'h9999, 5'd16, 1'b1, 1'b0);
        drive(16'hF000, 5'd4, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid",  {63'h0, out_valid},  64'h0);
        check("mid_rst_fifo_level", {60'h0, fifo_level}, 64'h0);
        check("mid_rst_overflow",   {63'h0, overflow},   64'h0);
        check("mid_rst_out_data",   {32'h0, out_data},   64'h0);
        sb.delete();
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        expect_word(32'hABCD_1234, 6'd32, 1'b0);
        drive(16'hABCD, 5'd16, 1'b1, 1'b0);
        drive(16'h1234, 5'd16, 1'b1, 1'b0);
        check("post_rst_data", {32'h0, out_data}, 64'hABCD_1234);
        idle(2);
`ifdef ARITH_BIT_PACKER_STATS_EN
        check("post_rst_total_bits", {32'h0, total_bits}, 64'd32);
        check("post_rst_dropped", {48'h0, dropped_words}, 64'h0);
`endif

        t = 0;
        while (sb.size() != 0 && t < 50) begin
            idle(1);
            t++;
        end
        check("scoreboard_drained", 64'(sb.size()), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
